surface_normal_engine: RTL and testbench

- Voxel surface-normal extractor for the ray-march pipeline; sits between the hit stage and shading.
- On a start pulse it converts the fixed-point hit position to a voxel index and fetches the centre voxel and its 6 face neighbours from voxel memory.
- It computes a central-difference density gradient, normalises it to signed 8-bit, and derives curvature and smoothness.
- Parametrised in grid size, coordinate format and memory read latency.

---
 rtl/surface_pkg.sv | 31 +++
 rtl/normal_normalizer.sv | 92 +++++++++
 rtl/surface_normal_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_surface_normal_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/surface_pkg.sv
// rtl/surface_pkg.sv - shared types and constants for the surface normal engine
//   state_t : engine FSM states
//   nbr_t   : voxel fetch order (centre, then -/+ face neighbours per axis)
//   constants: default normal, density field position, fetch count
package surface_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GRAD,
    S_NORM,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    NB_C,
    NB_XM,
    NB_XP,
    NB_YM,
    NB_YP,
    NB_ZM,
    NB_ZP
  } nbr_t;

  localparam logic signed [7:0] DEFAULT_NORMAL_Z = 8'sd127;
  localparam int DENSITY_LSB = 0;
  localparam int DENSITY_MSB = 7;
  localparam int N_FETCH     = 7;

endpackage

// File: rtl/normal_normalizer.sv
// rtl/normal_normalizer.sv - scales a 9-bit gradient into a signed 8-bit normal
//   gx, gy, gz          in  signed 9-bit central-difference gradient
//   ray_x, ray_y, ray_z in  signed ray direction, used only when the gradient is zero
//   nx, ny, nz          out signed 8-bit normal (combinational)
module normal_normalizer
  import surface_pkg::*;
#(
  parameter int COORD_WIDTH = 16
) (
  input  logic signed [8:0]             gx,
  input  logic signed [8:0]             gy,
  input  logic signed [8:0]             gz,
  input  logic signed [COORD_WIDTH-1:0] ray_x,
  input  logic signed [COORD_WIDTH-1:0] ray_y,
  input  logic signed [COORD_WIDTH-1:0] ray_z,
  output logic signed [7:0]             nx,
  output logic signed [7:0]             ny,
  output logic signed [7:0]             nz
);

  logic [8:0] ax, ay, az, m;
  logic [2:0] k;
  logic signed [8:0] sx, sy, sz;

  // One extra bit so the most negative ray component has a representable magnitude.
  logic signed [COORD_WIDTH:0] rx, ry, rz;
  logic [COORD_WIDTH:0] arx, ary, arz;

  assign rx = (COORD_WIDTH+1)'(ray_x);
  assign ry = (COORD_WIDTH+1)'(ray_y);
  assign rz = (COORD_WIDTH+1)'(ray_z);

  always_comb begin
    ax  = gx[8] ? 9'(-gx) : 9'(gx);
    ay  = gy[8] ? 9'(-gy) : 9'(gy);
    az  = gz[8] ? 9'(-gz) : 9'(gz);
    arx = rx[COORD_WIDTH] ? (COORD_WIDTH+1)'(-rx) : (COORD_WIDTH+1)'(rx);
    ary = ry[COORD_WIDTH] ? (COORD_WIDTH+1)'(-ry) : (COORD_WIDTH+1)'(ry);
    arz = rz[COORD_WIDTH] ? (COORD_WIDTH+1)'(-rz) : (COORD_WIDTH+1)'(rz);
    m   = ax;
    if (ay > m) m = ay;
    if (az > m) m = az;
  end

  // Smallest left shift that lifts a sub-64 maximum into 64..127.
  always_comb begin
    if (m[5])      k = 3'd1;
    else if (m[4]) k = 3'd2;
    else if (m[3]) k = 3'd3;
    else if (m[2]) k = 3'd4;
    else if (m[1]) k = 3'd5;
    else           k = 3'd6;
  end

  always_comb begin
    sx = gx;
    sy = gy;
    sz = gz;
    nx = '0;
    ny = '0;
    nz = '0;
    if (m > 9'd127) begin
      sx = gx >>> 1;
      sy = gy >>> 1;
      sz = gz >>> 1;
      nx = sx[7:0];
      ny = sy[7:0];
      nz = sz[7:0];
    end else if (m >= 9'd64) begin
      nx = gx[7:0];
      ny = gy[7:0];
      nz = gz[7:0];
    end else if (m != 9'd0) begin
      sx = gx <<< k;
      sy = gy <<< k;
      sz = gz <<< k;
      nx = sx[7:0];
      ny = sy[7:0];
      nz = sz[7:0];
    end else if (arx == '0 && ary == '0 && arz == '0) begin
      nz = DEFAULT_NORMAL_Z;
    end else if (arx >= ary && arx >= arz) begin
      // Flat density: face back toward the viewer along the dominant ray axis.
      nx = rx[COORD_WIDTH] ? 8'sd127 : -8'sd127;
    end else if (ary >= arz) begin
      ny = ry[COORD_WIDTH] ? 8'sd127 : -8'sd127;
    end else begin
      nz = rz[COORD_WIDTH] ? 8'sd127 : -8'sd127;
    end
  end

endmodule

// File: rtl/surface_normal_engine.sv
// rtl/surface_normal_engine.sv - voxel surface normal, curvature and smoothness extractor
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle request, sampled in IDLE
//   hit_x/y/z, ray_dir_x/y/z   signed fixed-point hit position and ray direction
//   voxel_addr, voxel_read_en  voxel memory read request (z*G*G + y*G + x)
//   voxel_data                 read data, MEM_LATENCY cycles after the strobe
//   normal_x/y/z               signed 8-bit normal
//   curvature, smoothness      curvature estimate and its complement
//   hit_valid, busy, done      status and one-cycle completion pulse
module surface_normal_engine
  import surface_pkg::*;
#(
  parameter int GRID_SIZE   = 64,
  parameter int COORD_WIDTH = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [COORD_WIDTH-1:0] hit_x,
  input  logic signed [COORD_WIDTH-1:0] hit_y,
  input  logic signed [COORD_WIDTH-1:0] hit_z,
  input  logic signed [COORD_WIDTH-1:0] ray_dir_x,
  input  logic signed [COORD_WIDTH-1:0] ray_dir_y,
  input  logic signed [COORD_WIDTH-1:0] ray_dir_z,
  output logic [ADDR_WIDTH-1:0]         voxel_addr,
  output logic                          voxel_read_en,
  input  logic [DATA_WIDTH-1:0]         voxel_data,
  output logic signed [7:0]             normal_x,
  output logic signed [7:0]             normal_y,
  output logic signed [7:0]             normal_z,
  output logic [7:0]                    curvature,
  output logic [7:0]                    smoothness,
  output logic                          hit_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = $clog2(GRID_SIZE);
  localparam logic signed [COORD_WIDTH-1:0] GRID_LIM = COORD_WIDTH'(GRID_SIZE);

  state_t state;

  logic signed [COORD_WIDTH-1:0] vx, vy, vz;
  logic miss;
  logic [IDX_W-1:0] ix, iy, iz;
  logic [IDX_W-1:0] ix_m, ix_p, iy_m, iy_p, iz_m, iz_p;
  logic [IDX_W-1:0] fx, fy, fz;
  logic signed [COORD_WIDTH-1:0] ray_x, ray_y, ray_z;
  logic [2:0] fcnt;
  logic [2:0] ret_cnt;
  logic [MEM_LATENCY-1:0] rd_pipe;
  logic [7:0] dens [N_FETCH];
  logic signed [8:0] gx, gy, gz;
  logic signed [11:0] lap;
  logic [11:0] lap_abs;
  logic [8:0] lap_sh;
  logic [7:0] curv_next;
  logic signed [7:0] nx, ny, nz;
  logic unused_data;

  // Only the density byte matters here; the rest of the voxel word serves other stages.
  assign unused_data = ^voxel_data[DATA_WIDTH-1:DENSITY_MSB+1];

  assign vx = hit_x >>> FRAC_BITS;
  assign vy = hit_y >>> FRAC_BITS;
  assign vz = hit_z >>> FRAC_BITS;
  assign miss = vx[COORD_WIDTH-1] || vy[COORD_WIDTH-1] || vz[COORD_WIDTH-1] ||
                (vx >= GRID_LIM) || (vy >= GRID_LIM) || (vz >= GRID_LIM);

  // Edge-replicate neighbours at the grid boundary.
  assign ix_m = (ix == '0) ? ix : ix - IDX_W'(1);
  assign ix_p = (&ix)      ? ix : ix + IDX_W'(1);
  assign iy_m = (iy == '0) ? iy : iy - IDX_W'(1);
  assign iy_p = (&iy)      ? iy : iy + IDX_W'(1);
  assign iz_m = (iz == '0) ? iz : iz - IDX_W'(1);
  assign iz_p = (&iz)      ? iz : iz + IDX_W'(1);

  always_comb begin
    fx = ix;
    fy = iy;
    fz = iz;
    case (nbr_t'(fcnt))
      NB_XM:   fx = ix_m;
      NB_XP:   fx = ix_p;
      NB_YM:   fy = iy_m;
      NB_YP:   fy = iy_p;
      NB_ZM:   fz = iz_m;
      NB_ZP:   fz = iz_p;
      default: ;
    endcase
  end

  always_comb begin
    lap_abs   = lap[11] ? 12'(-lap) : 12'(lap);
    lap_sh    = lap_abs[11:3];
    curv_next = (lap_sh > 9'd255) ? 8'd255 : lap_sh[7:0];
  end

  normal_normalizer #(
    .COORD_WIDTH(COORD_WIDTH)
  ) u_norm (
    .gx    (gx),
    .gy    (gy),
    .gz    (gz),
    .ray_x (ray_x),
    .ray_y (ray_y),
    .ray_z (ray_z),
    .nx    (nx),
    .ny    (ny),
    .nz    (nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      voxel_addr    <= '0;
      voxel_read_en <= 1'b0;
      normal_x      <= '0;
      normal_y      <= '0;
      normal_z      <= DEFAULT_NORMAL_Z;
      curvature     <= '0;
      smoothness    <= 8'hFF;
      hit_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ix            <= '0;
      iy            <= '0;
      iz            <= '0;
      ray_x         <= '0;
      ray_y         <= '0;
      ray_z         <= '0;
      fcnt          <= '0;
      ret_cnt       <= '0;
      rd_pipe       <= '0;
      gx            <= '0;
      gy            <= '0;
      gz            <= '0;
      lap           <= '0;
      for (int i = 0; i < N_FETCH; i++) dens[i] <= '0;
    end else begin
      // Strobe delay line: a set tail bit marks the cycle its read data is valid.
      rd_pipe[0] <= voxel_read_en;
      for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (rd_pipe[MEM_LATENCY-1]) begin
        dens[ret_cnt] <= voxel_data[DENSITY_MSB:DENSITY_LSB];
        ret_cnt       <= ret_cnt + 3'd1;
      end

      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (miss) begin
              normal_x   <= '0;
              normal_y   <= '0;
              normal_z   <= DEFAULT_NORMAL_Z;
              curvature  <= '0;
              smoothness <= 8'hFF;
              hit_valid  <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              ix            <= vx[IDX_W-1:0];
              iy            <= vy[IDX_W-1:0];
              iz            <= vz[IDX_W-1:0];
              ray_x         <= ray_dir_x;
              ray_y         <= ray_dir_y;
              ray_z         <= ray_dir_z;
              busy          <= 1'b1;
              ret_cnt       <= '0;
              fcnt          <= 3'd1;
              voxel_addr    <= ADDR_WIDTH'({vz[IDX_W-1:0], vy[IDX_W-1:0], vx[IDX_W-1:0]});
              voxel_read_en <= 1'b1;
              state         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (fcnt == 3'(N_FETCH)) begin
            voxel_read_en <= 1'b0;
            state         <= S_WAIT;
          end else begin
            voxel_addr <= ADDR_WIDTH'({fz, fy, fx});
            fcnt       <= fcnt + 3'd1;
          end
        end
        S_WAIT: begin
          if (rd_pipe[MEM_LATENCY-1] && ret_cnt == 3'(N_FETCH-1)) state <= S_GRAD;
        end
        S_GRAD: begin
          gx  <= $signed({1'b0, dens[NB_XM]}) - $signed({1'b0, dens[NB_XP]});
          gy  <= $signed({1'b0, dens[NB_YM]}) - $signed({1'b0, dens[NB_YP]});
          gz  <= $signed({1'b0, dens[NB_ZM]}) - $signed({1'b0, dens[NB_ZP]});
          lap <= $signed(12'(dens[NB_XM]) + 12'(dens[NB_XP]) + 12'(dens[NB_YM]) +
                         12'(dens[NB_YP]) + 12'(dens[NB_ZM]) + 12'(dens[NB_ZP])) -
                 $signed(12'(dens[NB_C]) * 12'd6);
          state <= S_NORM;
        end
        S_NORM: begin
          normal_x   <= nx;
          normal_y   <= ny;
          normal_z   <= nz;
          curvature  <= curv_next;
          smoothness <= 8'hFF - curv_next;
          hit_valid  <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_surface_normal_engine.sv
// tb/tb_surface_normal_engine.sv - directed bench for surface_normal_engine (latency 1 and 3 instances)
module tb_surface_normal_engine;

  localparam logic [55:0] FILL = 56'hA5A5A5A5A5A5A5;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic signed [15:0] hx, hy, hz, rx, ry, rz;
  int mode0, mode1;

  logic [17:0] addr0, addr1;
  logic re0, re1;
  logic [63:0] data0, data1;
  logic signed [7:0] nx0, ny0, nz0, nx1, ny1, nz1;
  logic [7:0] curv0, smooth0, curv1, smooth1;
  logic hv0, busy0, done0, hv1, busy1, done1;

  logic [63:0] m1_s0, m1_s1, m1_s2;
  int rd_cnt0 = 0;
  int rd_log[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  surface_normal_engine #(.MEM_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .hit_x(hx), .hit_y(hy), .hit_z(hz),
    .ray_dir_x(rx), .ray_dir_y(ry), .ray_dir_z(rz),
    .voxel_addr(addr0), .voxel_read_en(re0), .voxel_data(data0),
    .normal_x(nx0), .normal_y(ny0), .normal_z(nz0),
    .curvature(curv0), .smoothness(smooth0),
    .hit_valid(hv0), .busy(busy0), .done(done0)
  );

  surface_normal_engine #(.MEM_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .hit_x(hx), .hit_y(hy), .hit_z(hz),
    .ray_dir_x(rx), .ray_dir_y(ry), .ray_dir_z(rz),
    .voxel_addr(addr1), .voxel_read_en(re1), .voxel_data(data1),
    .normal_x(nx1), .normal_y(ny1), .normal_z(nz1),
    .curvature(curv1), .smoothness(smooth1),
    .hit_valid(hv1), .busy(busy1), .done(done1)
  );

  function automatic logic [7:0] dens_of(input int mode, input logic [17:0] a);
    int x;
    x = int'(a[5:0]);
    case (mode)
      0:       return (x <= 32) ? 8'd255 : 8'd0;
      1:       return 8'd100;
      default: return 8'(x * 10);
    endcase
  endfunction

  function automatic int addr_of(input int x, input int y, input int z);
    return z * 4096 + y * 64 + x;
  endfunction

  always @(posedge clk) begin
    if (re0) begin
      rd_log.push_back(int'(addr0));
      rd_cnt0 <= rd_cnt0 + 1;
    end
    data0 <= {FILL, dens_of(mode0, addr0)};
  end

  always @(posedge clk) begin
    m1_s0 <= {FILL, dens_of(mode1, addr1)};
    m1_s1 <= m1_s0;
    m1_s2 <= m1_s1;
  end
  assign data1 = m1_s2;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_hit(input int x, input int y, input int z, input int a, input int b, input int c);
    hx = 16'(x); hy = 16'(y); hz = 16'(z);
    rx = 16'(a); ry = 16'(b); rz = 16'(c);
  endtask

  // Returns the cycle offset from the start-sampling edge at which done is seen (-1 on timeout).
  task automatic launch(input int inst, output int lat);
    lat = -1;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((inst == 0) ? done0 : done1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    int rd_snap;
    int exp_a[7];

    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode0 = 0;
    mode1 = 0;
    set_hit(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_nx", nx0, 0);
    check("rst_ny", ny0, 0);
    check("rst_nz", nz0, 127);
    check("rst_curv", curv0, 0);
    check("rst_smooth", smooth0, 255);
    check("rst_hv", hv0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_re", re0, 0);
    check("rst_addr", addr0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plane x<=32 dense, hit (32.5,10,10)
    mode0 = 0;
    set_hit(8320, 2560, 2560, 0, 0, 0);
    rd_log.delete();
    launch(0, lat);
    check("plane_lat", lat, 11);
    check("plane_nx", nx0, 127);
    check("plane_ny", ny0, 0);
    check("plane_nz", nz0, 0);
    check("plane_curv", curv0, 31);
    check("plane_smooth", smooth0, 224);
    check("plane_hv", hv0, 1);
    check("plane_busy", busy0, 0);
    exp_a = '{addr_of(32, 10, 10), addr_of(31, 10, 10), addr_of(33, 10, 10),
              addr_of(32, 9, 10), addr_of(32, 11, 10), addr_of(32, 10, 9), addr_of(32, 10, 11)};
    check("plane_nreads", rd_log.size(), 7);
    for (int j = 0; j < 7; j++) check($sformatf("plane_addr%0d", j), rd_log[j], exp_a[j]);
    @(negedge clk);
    check("plane_done_pulse", done0, 0);

    // Uniform density: zero gradient, ray-based fallback
    mode0 = 1;
    set_hit(2560, 2560, 2560, 0, 0, -256);
    launch(0, lat);
    check("uni_lat", lat, 11);
    check("uni_z_nx", nx0, 0);
    check("uni_z_ny", ny0, 0);
    check("uni_z_nz", nz0, 127);
    check("uni_curv", curv0, 0);
    check("uni_smooth", smooth0, 255);
    set_hit(2560, 2560, 2560, -512, 256, 0);
    launch(0, lat);
    check("uni_x_nx", nx0, 127);
    check("uni_x_ny", ny0, 0);
    check("uni_x_nz", nz0, 0);
    set_hit(2560, 2560, 2560, 0, 128, 128);
    launch(0, lat);
    check("uni_tie_nx", nx0, 0);
    check("uni_tie_ny", ny0, -127);
    check("uni_tie_nz", nz0, 0);

    // Edge clamp at x=0 with density x*10
    mode0 = 2;
    set_hit(0, 1280, 1280, 0, 0, 0);
    rd_log.delete();
    launch(0, lat);
    check("edge_lat", lat, 11);
    check("edge_addr_c", rd_log[0], addr_of(0, 5, 5));
    check("edge_addr_xm", rd_log[1], addr_of(0, 5, 5));
    check("edge_addr_xp", rd_log[2], addr_of(1, 5, 5));
    check("edge_nx", nx0, -80);
    check("edge_ny", ny0, 0);
    check("edge_nz", nz0, 0);
    check("edge_curv", curv0, 1);
    check("edge_smooth", smooth0, 254);

    // Miss: x = -1.0
    set_hit(-256, 2560, 2560, 0, 0, 0);
    rd_snap = rd_cnt0;
    launch(0, lat);
    check("miss_lat", lat, 1);
    check("miss_hv", hv0, 0);
    check("miss_nx", nx0, 0);
    check("miss_ny", ny0, 0);
    check("miss_nz", nz0, 127);
    check("miss_curv", curv0, 0);
    check("miss_smooth", smooth0, 255);
    check("miss_busy", busy0, 0);
    repeat (3) @(negedge clk);
    check("miss_no_reads", rd_cnt0, rd_snap);

    // Latency 3, second start while busy is ignored
    mode1 = 0;
    set_hit(8320, 2560, 2560, 0, 0, 0);
    lat = -1;
    done_cnt = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) check("l3_busy", busy1, 1);
      if (done1) begin
        done_cnt++;
        if (lat < 0) lat = i;
      end
      start1 = (i == 3);
    end
    check("l3_lat", lat, 13);
    check("l3_done_cnt", done_cnt, 1);
    check("l3_nx", nx1, 127);
    check("l3_curv", curv1, 31);

    // Asynchronous reset mid-fetch, then a clean run
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_re", re1, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_re", re1, 0);
    check("arst_busy", busy1, 0);
    check("arst_done", done1, 0);
    check("arst_hv", hv1, 0);
    check("arst_nx", nx1, 0);
    check("arst_ny", ny1, 0);
    check("arst_nz", nz1, 127);
    check("arst_curv", curv1, 0);
    check("arst_smooth", smooth1, 255);
    check("arst_addr", addr1, 0);
    #1;
    rst_n = 1'b1;
    mode1 = 2;
    set_hit(0, 1280, 1280, 0, 0, 0);
    launch(1, lat);
    check("post_rst_lat", lat, 13);
    check("post_rst_nx", nx1, -80);
    check("post_rst_ny", ny1, 0);
    check("post_rst_nz", nz1, 0);
    check("post_rst_curv", curv1, 1);
    check("post_rst_smooth", smooth1, 254);
    check("post_rst_hv", hv1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
